// File: rtl/freqgen.sv
// Programmable square-wave generator: phase-accumulator divider producing
// `wave` at `freq` Hz, with an inc/dec button FSM (hold + auto-repeat) setting `freq`.
module freqgen #(
  parameter int CLKFREQ   = 27000000,
  parameter int MAXFREQ   = 9999,
  parameter int DEFFREQ   = 1000,
  parameter int HOLD_MS   = 500,
  parameter int REPEAT_MS = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce1ms,
  input  logic [1:0]  ptr,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        en,
  output logic [15:0] freq,
  output logic        wave,
  output logic        rise
);

  localparam int HALF   = CLKFREQ / 2;
  localparam int ACC_W  = $clog2(HALF + MAXFREQ + 1);
  localparam int SUM_W  = ((ACC_W > 16) ? ACC_W : 16) + 1;
  localparam int MS_MAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int MS_W   = $clog2(MS_MAX + 1);

  localparam logic [SUM_W-1:0] HALF_S     = SUM_W'(HALF);
  localparam logic [16:0]      MAXFREQ_17 = 17'(MAXFREQ);
  localparam logic [MS_W-1:0]  HOLD_LAST  = MS_W'(HOLD_MS - 1);
  localparam logic [MS_W-1:0]  REP_LAST   = MS_W'(REPEAT_MS - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_t;

  function automatic logic [15:0] step_of(input logic [1:0] p);
    case (p)
      2'd0:    step_of = 16'd1;
      2'd1:    step_of = 16'd10;
      2'd2:    step_of = 16'd100;
      default: step_of = 16'd1000;
    endcase
  endfunction

  // Both saturating helpers work 17 bits wide so neither direction can wrap.
  function automatic logic [15:0] sat_inc(input logic [15:0] f, input logic [15:0] st);
    logic [16:0] s;
    s = {1'b0, f} + {1'b0, st};
    if (s > MAXFREQ_17) sat_inc = MAXFREQ_17[15:0];
    else                sat_inc = s[15:0];
  endfunction

  function automatic logic [15:0] sat_dec(input logic [15:0] f, input logic [15:0] st);
    logic [16:0] d;
    d = {1'b0, f} - {1'b0, st};
    if (d[16]) sat_dec = 16'd0;
    else       sat_dec = d[15:0];
  endfunction

  logic [ACC_W-1:0] acc;
  logic [SUM_W-1:0] sum_p0;
  logic             wrap_p0;

  always_comb begin
    sum_p0  = SUM_W'(acc) + SUM_W'(freq);
    wrap_p0 = (sum_p0 >= HALF_S);
  end

  // Stage p0 -> registered wave/rise; accumulator keeps its residue across freq changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      wave <= 1'b0;
      rise <= 1'b0;
    end else if (en) begin
      if (wrap_p0) begin
        acc  <= ACC_W'(sum_p0 - HALF_S);
        wave <= ~wave;
        rise <= ~wave;
      end else begin
        acc  <= ACC_W'(sum_p0);
        rise <= 1'b0;
      end
    end else begin
      rise <= 1'b0;
    end
  end

  state_t          state;
  logic            inc_q;
  logic            dec_q;
  logic            dir_inc;
  logic [MS_W-1:0] ms_cnt;
  logic            inc_edge;
  logic            dec_edge;
  logic            act_btn;
  logic            oth_btn;
  logic [15:0]     step_val;
  logic [15:0]     freq_step;

  always_comb begin
    inc_edge  = btn_inc & ~inc_q;
    dec_edge  = btn_dec & ~dec_q;
    act_btn   = dir_inc ? btn_inc : btn_dec;
    oth_btn   = dir_inc ? btn_dec : btn_inc;
    step_val  = step_of(ptr);
    freq_step = dir_inc ? sat_inc(freq, step_val) : sat_dec(freq, step_val);
  end

  // Button FSM; the setpoint register is owned here so at most one step lands per clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      dir_inc <= 1'b0;
      ms_cnt  <= '0;
      freq    <= 16'(DEFFREQ);
    end else begin
      inc_q <= btn_inc;
      dec_q <= btn_dec;
      case (state)
        IDLE: begin
          if (inc_edge && !btn_dec) begin
            freq    <= sat_inc(freq, step_val);
            dir_inc <= 1'b1;
            ms_cnt  <= '0;
            state   <= HOLD;
          end else if (dec_edge && !btn_inc) begin
            freq    <= sat_dec(freq, step_val);
            dir_inc <= 1'b0;
            ms_cnt  <= '0;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (!act_btn || oth_btn) begin
            state <= IDLE;
          end else if (ce1ms) begin
            if (ms_cnt == HOLD_LAST) begin
              freq   <= freq_step;
              ms_cnt <= '0;
              state  <= REPEAT;
            end else begin
              ms_cnt <= ms_cnt + MS_W'(1);
            end
          end
        end
        REPEAT: begin
          if (!act_btn || oth_btn) begin
            state <= IDLE;
          end else if (ce1ms) begin
            if (ms_cnt == REP_LAST) begin
              freq   <= freq_step;
              ms_cnt <= '0;
            end else begin
              ms_cnt <= ms_cnt + MS_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
